// File: rtl/sdram_host_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sdram_host_bridge_pkg
//   Shared definitions for the SDRAM host bridge: FSM state encoding and the
//   default geometry / watchdog values used by the top level and its FIFO.
// -----------------------------------------------------------------------------
package sdram_host_bridge_pkg;

    localparam int MPB_FIFO_DEPTH  = 8;
    localparam int MPB_AW          = 20;
    localparam int MPB_DW          = 16;
    localparam int MPB_TIMEOUT_CYC = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } mpb_state_e;

endpackage

// File: rtl/sdram_host_bridge_fifo.sv
// -----------------------------------------------------------------------------
// sdram_host_bridge_fifo
//   Synchronous posted-write FIFO.
//   Entries are stored as {addx, wdata}.
//   Pointers carry one extra wrap bit, so full and empty can be told apart
//   without a separate counter.
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_din    write an entry (ignored when full)
//   i_pop            drop the head entry (ignored when empty)
//   o_dout           head entry (combinational read)
//   o_full, o_empty  status flags, derived from the registered pointers
//   o_level          occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sdram_host_bridge_fifo
    import sdram_host_bridge_pkg::*;
#(
    parameter  int DEPTH = MPB_FIFO_DEPTH,
    parameter  int W     = MPB_AW + MPB_DW,
    localparam int PW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [PW-1:0] o_level
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign o_level = r_wptr - r_rptr;
    assign o_dout  = r_mem[r_rptr[PW-2:0]];

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[PW-2:0]] <= i_din;
    end

endmodule

// File: rtl/sdram_host_bridge.sv
// -----------------------------------------------------------------------------
// sdram_host_bridge
//   Upstream stage of the SDRAM wrapper.
//   Host writes are posted into a FIFO and replayed as mp_* bus cycles:
//     IDLE -> SETUP -> STROBE -> HOLD -> RECOVER
//   Each cycle is paced by sdram_busy_l.
//   A read is issued only after the FIFO has drained, which keeps host order.
// Ports
//   sys_clk, sys_rst_l          clock, asynchronous active-low reset
//   h_req/h_we/h_addx/h_wdata   host request; accepted when h_req & h_ready
//   h_ready                     !fifo_full & !rd_pend
//   h_rdata/h_rvalid            read return (1-cycle pulse)
//   h_err                       watchdog timeout pulse
//   wfifo_level                 posted-write occupancy
//   mp_addx/mp_data_out/mp_data_oe/mp_cs_l/mp_wr_l/mp_rd_l
//                               registered controller interface
//   mp_data_in                  read data from the controller
//   sdram_busy_l                controller busy, active-low
// Configuration
//   MPB_TIMEOUT_EN  When defined, a strobe watchdog of TIMEOUT_CYC cycles
//                   aborts the mp cycle. When undefined, the FSM waits
//                   indefinitely and h_err is tied to 0.
// -----------------------------------------------------------------------------
module sdram_host_bridge
    import sdram_host_bridge_pkg::*;
#(
    parameter  int FIFO_DEPTH  = MPB_FIFO_DEPTH,
    parameter  int AW          = MPB_AW,
    parameter  int DW          = MPB_DW,
    parameter  int TIMEOUT_CYC = MPB_TIMEOUT_CYC,
    localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_l,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addx,
    input  logic [DW-1:0] h_wdata,
    output logic          h_ready,
    output logic [DW-1:0] h_rdata,
    output logic          h_rvalid,
    output logic          h_err,
    output logic [LW-1:0] wfifo_level,
    output logic [AW-1:0] mp_addx,
    output logic [DW-1:0] mp_data_out,
    output logic          mp_data_oe,
    input  logic [DW-1:0] mp_data_in,
    output logic          mp_cs_l,
    output logic          mp_wr_l,
    output logic          mp_rd_l,
    input  logic          sdram_busy_l
);

    mpb_state_e      r_state;
    logic            r_rd_pend;
    logic [AW-1:0]   r_rd_addx;
    logic            r_is_rd;
    logic [AW-1:0]   r_mp_addx;
    logic [DW-1:0]   r_mp_data_out;
    logic            r_mp_data_oe;
    logic            r_mp_cs_l;
    logic            r_mp_wr_l;
    logic            r_mp_rd_l;
    logic [DW-1:0]   r_h_rdata;
    logic            r_h_rvalid;

    logic [AW+DW-1:0] w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_acc;
    logic             w_push;
    logic             w_pop;
    logic             w_tmo;
    logic             w_end;

    assign h_ready = !w_fifo_full && !r_rd_pend;
    assign w_acc   = h_req && h_ready;
    assign w_push  = w_acc && h_we;
    assign w_pop   = (r_state == ST_IDLE) && !w_fifo_empty;

    sdram_host_bridge_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_l),
        .i_push  (w_push),
        .i_din   ({h_addx, h_wdata}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (wfifo_level)
    );

`ifdef MPB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_h_err;

    // The counter is 0 on the first STROBE cycle.
    // The abort therefore lands exactly TIMEOUT_CYC cycles after the strobes
    // go low.
    assign w_tmo = (r_state == ST_STROBE || r_state == ST_HOLD) &&
                   (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign h_err = r_h_err;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_tmo_cnt <= '0;
            r_h_err   <= 1'b0;
        end else begin
            r_h_err <= w_tmo;
            if (r_state == ST_STROBE || r_state == ST_HOLD) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                                           r_tmo_cnt <= '0;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC != 0);
    assign w_tmo        = 1'b0;
    assign h_err        = 1'b0;
`endif

    // The cycle ends normally when busy is released in HOLD.
    // It also ends early when the watchdog fires.
    assign w_end = ((r_state == ST_HOLD) && sdram_busy_l) || w_tmo;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_state       <= ST_IDLE;
            r_rd_pend     <= 1'b0;
            r_rd_addx     <= '0;
            r_is_rd       <= 1'b0;
            r_mp_addx     <= '0;
            r_mp_data_out <= '0;
            r_mp_data_oe  <= 1'b0;
            r_mp_cs_l     <= 1'b1;
            r_mp_wr_l     <= 1'b1;
            r_mp_rd_l     <= 1'b1;
            r_h_rdata     <= '0;
            r_h_rvalid    <= 1'b0;
        end else begin
            r_h_rvalid <= 1'b0;
            if (w_acc && !h_we) begin
                r_rd_pend <= 1'b1;
                r_rd_addx <= h_addx;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_mp_addx     <= w_fifo_dout[AW+DW-1:DW];
                        r_mp_data_out <= w_fifo_dout[DW-1:0];
                        r_mp_data_oe  <= 1'b1;
                        r_is_rd       <= 1'b0;
                        r_state       <= ST_SETUP;
                    end else if (r_rd_pend) begin
                        r_mp_addx <= r_rd_addx;
                        r_is_rd   <= 1'b1;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_mp_cs_l <= 1'b0;
                    if (r_is_rd) r_mp_rd_l <= 1'b0;
                    else         r_mp_wr_l <= 1'b0;
                    r_state <= ST_STROBE;
                end
                ST_STROBE, ST_HOLD: begin
                    if (w_end) begin
                        r_mp_cs_l    <= 1'b1;
                        r_mp_wr_l    <= 1'b1;
                        r_mp_rd_l    <= 1'b1;
                        r_mp_data_oe <= 1'b0;
                        if (r_is_rd) begin
                            r_h_rvalid <= 1'b1;
                            r_h_rdata  <= w_tmo ? '0 : mp_data_in;
                            r_rd_pend  <= 1'b0;
                        end
                        r_state <= ST_RECOVER;
                    end else if (r_state == ST_STROBE && !sdram_busy_l) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_RECOVER: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign mp_addx     = r_mp_addx;
    assign mp_data_out = r_mp_data_out;
    assign mp_data_oe  = r_mp_data_oe;
    assign mp_cs_l     = r_mp_cs_l;
    assign mp_wr_l     = r_mp_wr_l;
    assign mp_rd_l     = r_mp_rd_l;
    assign h_rdata     = r_h_rdata;
    assign h_rvalid    = r_h_rvalid;

endmodule
